// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
//   Memory-side responder for the CPU instruction and data channels. It serves
//   instruction fetches (PC) and data loads/stores (Address) from a single
//   word-organised array of 2^ADDR_WIDTH 32-bit words. Only one transaction
//   is in flight at a time.
//
//   Request acceptance and response delivery both have programmable latency,
//   so a wrapper can drive the CPU through all of its wait states.
//
//   Optional build macro: MEM_RAND_LAT_EN
//     Adds 0..3 pseudo-random extra wait cycles, taken from an 8-bit LFSR, to
//     every latency load. Without the macro both latencies are exact.
//
// Handshake semantics (all channels):
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. The requester holds valid, and its payload, stable until that edge.
//   Ready and Valid outputs are decoded only from registered state, so there
//   is no combinational path from any input to any output.
//
// Ports:
//   clk, rst                   clock and asynchronous active-high reset
//   PC, Inst_Req_Valid         fetch request (byte address)
//   Inst_Req_Ready             fetch request accepted (one-cycle pulse)
//   Instruction, Inst_Valid    fetched word and its valid flag
//   Inst_Ready                 CPU accepts Instruction
//   Address                    data byte address; bits [1:0] are ignored
//   MemWrite, Write_data,      store request, lane-aligned data and
//   Write_strb                 byte enables
//   MemRead                    load request
//   Mem_Req_Ready              data request accepted (one-cycle pulse)
//   Read_data, Read_data_Valid loaded word and its valid flag
//   Read_data_Ready            CPU accepts Read_data
module cpu_mem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int REQ_LAT    = 2,
    parameter int RESP_LAT   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        Inst_Req_Valid,
    output logic        Inst_Req_Ready,
    output logic [31:0] Instruction,
    output logic        Inst_Valid,
    input  logic        Inst_Ready,
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    input  logic        MemRead,
    output logic        Mem_Req_Ready,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ready
);

    typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_RESP_DELAY, S_RESP} state_t;
    typedef enum logic [1:0] {K_INST, K_LOAD, K_STORE} kind_t;

    localparam logic [3:0] REQ_LAT_C  = 4'(REQ_LAT);
    localparam logic [3:0] RESP_LAT_C = 4'(RESP_LAT);

    logic [31:0] mem [2**ADDR_WIDTH];

    state_t                  state_q, state_d;
    kind_t                   kind_q, kind_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [31:0]             inst_q, inst_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    mem_we;
    logic [3:0]              req_cnt_init;
    logic [3:0]              resp_cnt_init;

    // Upper address bits are dropped here, which makes addresses wrap
    // modulo the array size.
    logic [ADDR_WIDTH-1:0]   addr_idx;
    logic [ADDR_WIDTH-1:0]   pc_idx;
    logic [31:0]             mem_rdata;
    logic                    req_valid_sel;
    logic                    resp_ready_sel;

    assign addr_idx  = Address[ADDR_WIDTH+1:2];
    assign pc_idx    = PC[ADDR_WIDTH+1:2];
    assign mem_rdata = mem[idx_q];

    // Byte-offset and above-array address bits have no function.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{PC[31:ADDR_WIDTH+2], PC[1:0],
                                Address[31:ADDR_WIDTH+2], Address[1:0]};

`ifdef MEM_RAND_LAT_EN
    // Fibonacci LFSR, taps 8,6,5,4; free-running.
    logic [7:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= 8'hA5;
        else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    // Base latency plus 0..3 extra cycles, saturated to fit the 4-bit counter.
    function automatic logic [3:0] lat_load(input logic [3:0] base, input logic [1:0] extra);
        logic [4:0] sum;
        sum = {1'b0, base} + {3'b000, extra};
        return sum[4] ? 4'hF : sum[3:0];
    endfunction

    assign req_cnt_init  = lat_load(REQ_LAT_C, lfsr[1:0]);
    assign resp_cnt_init = lat_load(RESP_LAT_C, lfsr[1:0]);
`else
    assign req_cnt_init  = REQ_LAT_C;
    assign resp_cnt_init = RESP_LAT_C;
`endif

    always_comb begin
        req_valid_sel = 1'b0;
        case (kind_q)
            K_INST:  req_valid_sel = Inst_Req_Valid;
            K_LOAD:  req_valid_sel = MemRead;
            K_STORE: req_valid_sel = MemWrite;
            default: req_valid_sel = 1'b0;
        endcase
    end

    assign resp_ready_sel = (kind_q == K_INST) ? Inst_Ready : Read_data_Ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            kind_q  <= K_INST;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            inst_q  <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            inst_q  <= inst_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        inst_d  = inst_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Data requests take priority over fetches; a store wins
                // over a load.
                if (MemRead || MemWrite) begin
                    kind_d  = MemWrite ? K_STORE : K_LOAD;
                    state_d = S_ACCEPT;
                    cnt_d   = req_cnt_init;
                end else if (Inst_Req_Valid) begin
                    kind_d  = K_INST;
                    state_d = S_ACCEPT;
                    cnt_d   = req_cnt_init;
                end
            end
            S_ACCEPT: begin
                if (!req_valid_sel) begin
                    // Requester withdrew: drop the request with no side effect.
                    state_d = S_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (kind_q == K_STORE) begin
                    mem_we  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idx_d   = (kind_q == K_INST) ? pc_idx : addr_idx;
                    cnt_d   = resp_cnt_init;
                    state_d = S_RESP_DELAY;
                end
            end
            S_RESP_DELAY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (kind_q == K_INST) inst_d  = mem_rdata;
                    else                  rdata_d = mem_rdata;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready_sel) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory is not reset. mem_we is only ever high in ACCEPT, so reset
    // before the handshake cycle prevents the write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (Write_strb[b]) mem[addr_idx][8*b +: 8] <= Write_data[8*b +: 8];
            end
        end
    end

    assign Inst_Req_Ready  = (state_q == S_ACCEPT) && (cnt_q == 4'd0) && (kind_q == K_INST);
    assign Mem_Req_Ready   = (state_q == S_ACCEPT) && (cnt_q == 4'd0) && (kind_q != K_INST);
    assign Inst_Valid      = (state_q == S_RESP) && (kind_q == K_INST);
    assign Read_data_Valid = (state_q == S_RESP) && (kind_q != K_INST);
    assign Instruction     = inst_q;
    assign Read_data       = rdata_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder (default build, REQ_LAT=2,
// RESP_LAT=3, ADDR_WIDTH=12). Inputs change and outputs are sampled 1 ns
// after each rising clock edge.
module tb_cpu_mem_responder;
  localparam int AW = 12;
  localparam int RL = 2;
  localparam int SL = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ready;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ready;
  logic [31:0] Address;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        MemRead;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  cpu_mem_responder #(.ADDR_WIDTH(AW), .REQ_LAT(RL), .RESP_LAT(SL)) dut (
    .clk(clk), .rst(rst), .PC(PC), .Inst_Req_Valid(Inst_Req_Valid),
    .Inst_Req_Ready(Inst_Req_Ready), .Instruction(Instruction), .Inst_Valid(Inst_Valid),
    .Inst_Ready(Inst_Ready), .Address(Address), .MemWrite(MemWrite),
    .Write_data(Write_data), .Write_strb(Write_strb), .MemRead(MemRead),
    .Mem_Req_Ready(Mem_Req_Ready), .Read_data(Read_data),
    .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int lat;
    bit seen;
    lat = 0;
    seen = 0;
    Address = addr; Write_data = data; Write_strb = strb; MemWrite = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (Mem_Req_Ready) begin seen = 1; break; end
      tick(); lat++;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL store_ready timeout addr=%h", addr);
    end else if (lat != 1 + RL) begin
      errors++; $display("FAIL store_ready_lat got %0d want %0d", lat, 1 + RL);
    end
    tick();
    MemWrite = 1'b0;
    checks++;
    if (Mem_Req_Ready !== 1'b0) begin
      errors++; $display("FAIL store_ready_pulse got %b want 0", Mem_Req_Ready);
    end
  endtask

  task automatic drive_load(input logic [31:0] addr, input logic [31:0] expv, input int hold);
    int lat;
    bit seen;
    logic [31:0] e;
    exp_q.push_back(expv);
    lat = 0;
    seen = 0;
    Address = addr; MemRead = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (Mem_Req_Ready) begin seen = 1; break; end
      tick(); lat++;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL load_ready timeout addr=%h", addr);
    end else if (lat != 1 + RL) begin
      errors++; $display("FAIL load_ready_lat got %0d want %0d", lat, 1 + RL);
    end
    tick();
    MemRead = 1'b0;
    lat = 1;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (Read_data_Valid) begin seen = 1; break; end
      tick(); lat++;
    end
    e = exp_q.pop_front();
    checks++;
    if (!seen) begin
      errors++; $display("FAIL load_valid timeout addr=%h", addr);
      return;
    end
    if (lat != 2 + SL) begin
      errors++; $display("FAIL load_valid_lat got %0d want %0d", lat, 2 + SL);
    end
    checks++;
    if (Read_data !== e) begin
      errors++; $display("FAIL load_data addr=%h got %h want %h", addr, Read_data, e);
    end
    for (int k = 0; k < hold; k++) begin
      tick();
      checks++;
      if (Read_data_Valid !== 1'b1 || Read_data !== e) begin
        errors++; $display("FAIL load_hold cycle %0d got v=%b d=%h want v=1 d=%h", k, Read_data_Valid, Read_data, e);
      end
    end
    Read_data_Ready = 1'b1;
    tick();
    Read_data_Ready = 1'b0;
    checks++;
    if (Read_data_Valid !== 1'b0 || Read_data !== e) begin
      errors++; $display("FAIL load_drop got v=%b d=%h want v=0 d=%h", Read_data_Valid, Read_data, e);
    end
  endtask

  task automatic drive_fetch(input logic [31:0] pc, input logic [31:0] expv, input int hold);
    int lat;
    bit seen;
    logic [31:0] e;
    exp_q.push_back(expv);
    lat = 0;
    seen = 0;
    PC = pc; Inst_Req_Valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (Inst_Req_Ready) begin seen = 1; break; end
      tick(); lat++;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL fetch_ready timeout pc=%h", pc);
    end else if (lat != 1 + RL) begin
      errors++; $display("FAIL fetch_ready_lat got %0d want %0d", lat, 1 + RL);
    end
    tick();
    Inst_Req_Valid = 1'b0;
    lat = 1;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (Inst_Valid) begin seen = 1; break; end
      tick(); lat++;
    end
    e = exp_q.pop_front();
    checks++;
    if (!seen) begin
      errors++; $display("FAIL fetch_valid timeout pc=%h", pc);
      return;
    end
    if (lat != 2 + SL) begin
      errors++; $display("FAIL fetch_valid_lat got %0d want %0d", lat, 2 + SL);
    end
    checks++;
    if (Instruction !== e) begin
      errors++; $display("FAIL fetch_data pc=%h got %h want %h", pc, Instruction, e);
    end
    for (int k = 0; k < hold; k++) begin
      tick();
      checks++;
      if (Inst_Valid !== 1'b1 || Instruction !== e) begin
        errors++; $display("FAIL fetch_hold cycle %0d got v=%b d=%h want v=1 d=%h", k, Inst_Valid, Instruction, e);
      end
    end
    Inst_Ready = 1'b1;
    tick();
    Inst_Ready = 1'b0;
    checks++;
    if (Inst_Valid !== 1'b0 || Instruction !== e) begin
      errors++; $display("FAIL fetch_drop got v=%b d=%h want v=0 d=%h", Inst_Valid, Instruction, e);
    end
  endtask

  // ---------------- tests ----------------
  task automatic check_outputs_zero(input string tag);
    checks++;
    if ({Inst_Req_Ready, Mem_Req_Ready, Inst_Valid, Read_data_Valid} !== 4'b0000) begin
      errors++; $display("FAIL %s_flags got %b want 0000", tag,
                         {Inst_Req_Ready, Mem_Req_Ready, Inst_Valid, Read_data_Valid});
    end
    checks++;
    if (Instruction !== 32'd0 || Read_data !== 32'd0) begin
      errors++; $display("FAIL %s_data got inst=%h rd=%h want 0", tag, Instruction, Read_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    PC = '0; Inst_Req_Valid = 0; Inst_Ready = 0; Address = '0; MemWrite = 0;
    Write_data = '0; Write_strb = '0; MemRead = 0; Read_data_Ready = 0;
    tick(); tick();
    check_outputs_zero("reset");
    #2 rst = 1'b0;
    tick();
    check_outputs_zero("post_reset");
  endtask

  task automatic test_store_load();
    drive_store(32'h10, 32'hDEADBEEF, 4'b1111);
    drive_load(32'h10, 32'hDEADBEEF, 0);
  endtask

  task automatic test_byte_strobe();
    drive_store(32'h20, 32'h11223344, 4'b1111);
    drive_store(32'h20, 32'h00AB0000, 4'b0100);
    drive_load(32'h20, 32'h11AB3344, 1);
    drive_store(32'h20, 32'hFFFFFFFF, 4'b0000);
    drive_load(32'h20, 32'h11AB3344, 0);
  endtask

  task automatic test_fetch_stall();
    drive_fetch(32'h10, 32'hDEADBEEF, 5);
  endtask

  task automatic test_priority();
    int lat;
    bit seen;
    bit inst_early;
    logic [31:0] e;
    lat = 0; seen = 0; inst_early = 0;
    Address = 32'h20; MemRead = 1'b1;
    PC = 32'h10; Inst_Req_Valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (Inst_Req_Ready) inst_early = 1;
      if (Mem_Req_Ready) begin seen = 1; break; end
      tick(); lat++;
    end
    checks++;
    if (!seen || lat != 1 + RL) begin
      errors++; $display("FAIL prio_mem_ready got seen=%0d lat=%0d want lat %0d", seen, lat, 1 + RL);
    end
    exp_q.push_back(32'h11AB3344);
    tick();
    MemRead = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (Inst_Req_Ready) inst_early = 1;
      if (Read_data_Valid) begin seen = 1; break; end
      tick();
    end
    e = exp_q.pop_front();
    checks++;
    if (!seen || Read_data !== e) begin
      errors++; $display("FAIL prio_load_data got seen=%0d d=%h want %h", seen, Read_data, e);
    end
    Read_data_Ready = 1'b1;
    tick();
    Read_data_Ready = 1'b0;
    checks++;
    if (inst_early) begin
      errors++; $display("FAIL prio_inst_early got Inst_Req_Ready before load done want none");
    end
    // The fetch has been pending all along and now gets its turn.
    lat = 0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (Inst_Req_Ready) begin seen = 1; break; end
      tick(); lat++;
    end
    checks++;
    if (!seen || lat != 1 + RL) begin
      errors++; $display("FAIL prio_inst_ready got seen=%0d lat=%0d want lat %0d", seen, lat, 1 + RL);
    end
    exp_q.push_back(32'hDEADBEEF);
    tick();
    Inst_Req_Valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (Inst_Valid) begin seen = 1; break; end
      tick();
    end
    e = exp_q.pop_front();
    checks++;
    if (!seen || Instruction !== e) begin
      errors++; $display("FAIL prio_fetch_data got seen=%0d d=%h want %h", seen, Instruction, e);
    end
    Inst_Ready = 1'b1;
    tick();
    Inst_Ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit bad;
    // Load abandoned in RESP_DELAY.
    Address = 32'h10; MemRead = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (Mem_Req_Ready) break;
      tick();
    end
    tick();
    MemRead = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    check_outputs_zero("reset_mid");
    tick();
    #2 rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (Read_data_Valid !== 1'b0 || Read_data !== 32'd0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL reset_mid_no_resp got late Read_data_Valid or data want none");
    end
    // Store abandoned in ACCEPT must not reach memory.
    Address = 32'h10; Write_data = 32'h0; Write_strb = 4'b1111; MemWrite = 1'b1;
    tick(); tick();
    #2 rst = 1'b1;
    MemWrite = 1'b0;
    #2 rst = 1'b0;
    tick();
    drive_load(32'h10, 32'hDEADBEEF, 0);
  endtask

  task automatic test_wrap_abort();
    bit bad;
    drive_store(32'h4010, 32'h5A5A5A5A, 4'b1111);
    drive_load(32'h0010, 32'h5A5A5A5A, 0);
    // MemRead withdrawn during ACCEPT.
    Address = 32'h10; MemRead = 1'b1;
    tick();
    MemRead = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (Mem_Req_Ready !== 1'b0 || Read_data_Valid !== 1'b0) bad = 1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL abort_no_activity got ready/valid after abort want none");
    end
    drive_load(32'h0010, 32'h5A5A5A5A, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr;
    logic [31:0] data;
    for (int i = 0; i < 6; i++) begin
      addr = 32'h100 + {$urandom_range(0, 15), 2'b00};
      data = $urandom;
      drive_store(addr, data, 4'b1111);
      if (i % 2 == 1) drive_fetch(addr, data, $urandom_range(0, 3));
      else            drive_load(addr, data, $urandom_range(0, 3));
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_store_load();
    test_byte_strobe();
    test_fetch_stall();
    test_priority();
    test_reset_mid();
    test_wrap_abort();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the custom CPU's instruction and data channels.
- Accepts instruction fetches (PC) and data load/store requests (Address) and answers them from one word-organised memory array.
- Request-accept and response latencies are programmable, so bench and FPGA wrappers can exercise every CPU wait state (IF, IW, LD, ST, RDW).
- Exactly one transaction is outstanding at a time.

Parameters:
- ADDR_WIDTH, 12, word-address bits; memory depth is 2^ADDR_WIDTH 32-bit words.
- REQ_LAT, 2, cycles spent in ACCEPT before the request Ready asserts (0..15).
- RESP_LAT, 3, cycles spent in RESP_DELAY before the response Valid asserts (0..15).

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  asynchronous active-high reset.
- PC  in  32  instruction byte address.
- Inst_Req_Valid  in  1  fetch request.
- Inst_Req_Ready  out  1  fetch request accepted.
- Instruction  out  32  fetched word.
- Inst_Valid  out  1  Instruction valid.
- Inst_Ready  in  1  CPU accepts Instruction.
- Address  in  32  data byte address; bits [1:0] ignored.
- MemWrite  in  1  store request.
- Write_data  in  32  store data, already lane-aligned.
- Write_strb  in  4  byte enables; bit i covers bits [8i+7:8i].
- MemRead  in  1  load request.
- Mem_Req_Ready  out  1  data request accepted.
- Read_data  out  32  loaded word.
- Read_data_Valid  out  1  Read_data valid.
- Read_data_Ready  in  1  CPU accepts Read_data.

Behaviour:
- States: IDLE, ACCEPT, RESP_DELAY, RESP. Registers: kind (INST/LOAD/STORE), 4-bit cnt, latched word index, response data.
- Reset, asynchronous, takes effect immediately:
  - State goes to IDLE and cnt to 0.
  - All outputs go to 0: Ready signals, Valid signals, Instruction, Read_data.
  - Memory contents are not reset.
- IDLE:
  - If MemRead or MemWrite is high, go to ACCEPT with kind=LOAD or STORE; MemWrite wins if both are high.
  - Otherwise, if Inst_Req_Valid is high, go to ACCEPT with kind=INST. Data requests have priority over fetches.
  - cnt is loaded with REQ_LAT.
- ACCEPT:
  - If the matching request valid is low, the request is aborted: return to IDLE with no side effect.
  - Otherwise, while cnt!=0, decrement cnt.
  - When cnt==0, assert the matching Ready for exactly one cycle. This is the handshake cycle h.
  - At h, a STORE writes the strobed bytes of Write_data to mem[Address[ADDR_WIDTH+1:2]] and returns to IDLE.
  - At h, a LOAD or INST latches its word index (from Address or PC) into the latched word index, loads cnt with RESP_LAT and goes to RESP_DELAY.
- Ready timing:
  - A request first seen high in IDLE at cycle t gets Ready at cycle t+1+REQ_LAT.
  - Ready is decoded only from registered state; there is no input-to-output combinational path.
- RESP_DELAY:
  - Decrement cnt.
  - At cnt==0, read mem at the latched word index into Instruction or Read_data and go to RESP.
  - Valid first asserts at h+2+RESP_LAT.
- RESP:
  - The matching Valid stays high with data stable until the matching CPU Ready is high.
  - On that cycle the transfer completes; Valid drops the next cycle and the state returns to IDLE.
  - Data outputs hold their last value after the transfer.
- Addressing:
  - Upper address bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo 4*2^ADDR_WIDTH.
  - A store with Write_strb=0000 completes the handshake and writes nothing.
- Fetches and data accesses share one array, so a store is visible to the next fetch.
- A read issued directly after a write to the same word returns the new data.
- Reset in any state abandons the transaction. A store whose handshake cycle has not yet occurred is never written.

Optional Feature:
- Macro: MEM_RAND_LAT_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) resets to 8'hA5 and advances every cycle.
  - Every cnt load adds lfsr[1:0] to REQ_LAT or RESP_LAT, giving 0..3 extra random wait cycles; cnt is saturated at 15.
- Undefined: the LFSR is absent and latencies are exactly REQ_LAT and RESP_LAT.

Test Plan:
- REQ_LAT=2, RESP_LAT=3. Store: MemWrite=1, Address=0x10, Write_data=0xDEADBEEF, strb=1111 at cycle t -> Mem_Req_Ready=1 at t+3 only. Load 0x10 -> Read_data=0xDEADBEEF, Read_data_Valid rises 5 cycles after the handshake.
- Word 0x20 holds 0x11223344. Store Write_data=0x00AB0000, strb=0100 -> load of 0x20 returns 0x11AB3344. A strb=0000 store leaves the word unchanged.
- Fetch PC=0x10 with Inst_Ready held low for 5 cycles after Inst_Valid -> Inst_Valid and Instruction=0xDEADBEEF stay stable. Inst_Valid drops the cycle after Inst_Ready=1.
- MemRead (Address=0x20) and Inst_Req_Valid (PC=0x10) both high in IDLE -> Mem_Req_Ready asserts first and Read_data=0x11AB3344 completes. Inst_Req_Ready asserts only afterwards.
- rst pulsed mid-RESP_DELAY of a load -> Read_data_Valid stays 0, all outputs 0 at once, state IDLE. A store aborted in ACCEPT by reset leaves memory unchanged.
- ADDR_WIDTH=12: store 0x5A5A5A5A at 0x4010 -> load at 0x0010 returns 0x5A5A5A5A. MemRead dropped during ACCEPT -> no Read_data_Valid, back to IDLE.
